gate_truth_checker: RTL and testbench



---
 rtl/gate_truth_checker.sv | 88 ++++++++
 tb/tb_gate_truth_checker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// Two-input gate tester: walks {I1,I2} through all four vectors, samples O after
// SETTLE cycles per vector, and scores each sample against the TRUTH table.
module gate_truth_checker #(
  parameter logic [3:0]  TRUTH  = 4'b0111,
  parameter int unsigned SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       O,
  output logic       I1,
  output logic       I2,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_MASK,
  output logic [7:0] RUN_CNT
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_settle_check
    $error("gate_truth_checker: SETTLE=%0d is outside 1..15", SETTLE);
  end

  localparam logic [3:0] SettleLoad = 4'(SETTLE);

  typedef enum logic {StIdle, StRun} state_e;

  state_e     state_q;
  logic [1:0] idx_q;
  logic [3:0] cnt_q;
  logic       miss;
  logic [3:0] err_next;

  // Fold the current vector's compare into the mask so the final PASS sees it.
  assign miss     = (O != TRUTH[idx_q]);
  assign err_next = ERR_MASK | (miss ? (4'b0001 << idx_q) : 4'b0000);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      idx_q    <= 2'd0;
      cnt_q    <= 4'd0;
      I1       <= 1'b0;
      I2       <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PASS     <= 1'b0;
      ERR_MASK <= 4'b0000;
      RUN_CNT  <= 8'd0;
    end else begin
      DONE <= 1'b0;
      case (state_q)
        StIdle: begin
          if (START) begin
            state_q  <= StRun;
            idx_q    <= 2'd0;
            {I1, I2} <= 2'b00;
            cnt_q    <= SettleLoad;
            ERR_MASK <= 4'b0000;
            PASS     <= 1'b0;
            BUSY     <= 1'b1;
          end
        end
        StRun: begin
          if (cnt_q == 4'd1) begin
            ERR_MASK <= err_next;
            if (idx_q == 2'd3) begin
              state_q  <= StIdle;
              {I1, I2} <= 2'b00;
              BUSY     <= 1'b0;
              DONE     <= 1'b1;
              PASS     <= (err_next == 4'b0000);
              RUN_CNT  <= RUN_CNT + 8'd1;
            end else begin
              idx_q    <= idx_q + 2'd1;
              {I1, I2} <= idx_q + 2'd1;
              cnt_q    <= SettleLoad;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: default instance on a selectable gate model,
// plus a SETTLE=5 instance wired to a stuck-at-1 output.
module tb_gate_truth_checker;

  localparam int GNand = 0, GAnd = 1, GOr = 2, GXor = 3, GStuck1 = 4;

  logic       CLK = 1'b0;
  logic       RST, START, O;
  logic       I1, I2, BUSY, DONE, PASS;
  logic [3:0] ERR_MASK;
  logic [7:0] RUN_CNT;

  logic       start5, o5;
  logic       i1_5, i2_5, busy5, done5, pass5;
  logic [3:0] err5;
  logic [7:0] cnt5;

  int         gate;
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_cnt;

  always #5 CLK = ~CLK;

  always_comb begin
    O = 1'b0;
    case (gate)
      GNand:   O = ~(I1 & I2);
      GAnd:    O = I1 & I2;
      GOr:     O = I1 | I2;
      GXor:    O = I1 ^ I2;
      default: O = 1'b1;
    endcase
  end

  gate_truth_checker dut (
    .CLK(CLK), .RST(RST), .START(START), .O(O), .I1(I1), .I2(I2), .BUSY(BUSY),
    .DONE(DONE), .PASS(PASS), .ERR_MASK(ERR_MASK), .RUN_CNT(RUN_CNT)
  );

  gate_truth_checker #(.SETTLE(5)) dut5 (
    .CLK(CLK), .RST(RST), .START(start5), .O(o5), .I1(i1_5), .I2(i2_5), .BUSY(busy5),
    .DONE(done5), .PASS(pass5), .ERR_MASK(err5), .RUN_CNT(cnt5)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " i"}, {30'd0, I1, I2}, 32'd0);
    check({tag, " busy"}, {31'd0, BUSY}, 32'd0);
    check({tag, " done"}, {31'd0, DONE}, 32'd0);
    check({tag, " pass"}, {31'd0, PASS}, 32'd0);
    check({tag, " err"}, {28'd0, ERR_MASK}, 32'd0);
    check({tag, " cnt"}, {24'd0, RUN_CNT}, 32'd0);
  endtask

  // Pulse START, wait (bounded) for DONE, then score latency and results.
  task automatic do_run(input string tag, input logic [3:0] exp_err, input int exp_lat);
    int lat;
    START = 1'b1;
    tick();
    START = 1'b0;
    lat = 0;
    while (!DONE && lat < 100) begin
      tick();
      lat++;
    end
    exp_cnt = exp_cnt + 8'd1;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy"}, {31'd0, BUSY}, 32'd0);
    check({tag, " err"}, {28'd0, ERR_MASK}, {28'd0, exp_err});
    check({tag, " pass"}, {31'd0, PASS}, {31'd0, exp_err == 4'b0000});
    check({tag, " cnt"}, {24'd0, RUN_CNT}, {24'd0, exp_cnt});
    tick();
    check({tag, " done pulse"}, {31'd0, DONE}, 32'd0);
  endtask

  initial begin
    int         t, ndone;
    int         done_at[3];
    logic       all_pass;
    RST = 1'b1; START = 1'b0; start5 = 1'b0; o5 = 1'b1; gate = GNand; exp_cnt = 8'd0;
    tick();
    tick();
    RST = 1'b0;
    check_reset("reset");

    // NAND, cycle-by-cycle view of the first run
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int e = 0; e < 8; e++) begin
      check($sformatf("nand vec e%0d", e), {30'd0, I1, I2}, e / 2);
      check($sformatf("nand busy e%0d", e), {31'd0, BUSY}, 32'd1);
      check($sformatf("nand done e%0d", e), {31'd0, DONE}, 32'd0);
      tick();
    end
    exp_cnt = 8'd1;
    check("nand done", {31'd0, DONE}, 32'd1);
    check("nand busy end", {31'd0, BUSY}, 32'd0);
    check("nand pass", {31'd0, PASS}, 32'd1);
    check("nand err", {28'd0, ERR_MASK}, 32'd0);
    check("nand cnt", {24'd0, RUN_CNT}, 32'd1);
    check("nand vec end", {30'd0, I1, I2}, 32'd0);
    tick();

    // Wrong gates against the NAND table; mask is rebuilt each run
    gate = GAnd;
    do_run("and", 4'b1111, 8);
    gate = GOr;
    do_run("or", 4'b1001, 8);
    gate = GXor;
    do_run("xor", 4'b0001, 8);
    gate = GStuck1;
    do_run("stuck1", 4'b1000, 8);
    check("held err", {28'd0, ERR_MASK}, 32'h8);
    check("held pass", {31'd0, PASS}, 32'd0);

    // SETTLE=5 instance: DONE after edge 20
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    t = 0;
    while (!done5 && t < 100) begin
      tick();
      t++;
    end
    check("settle5 latency", t, 20);
    check("settle5 err", {28'd0, err5}, 32'h8);
    check("settle5 pass", {31'd0, pass5}, 32'd0);
    check("settle5 cnt", {24'd0, cnt5}, 32'd1);

    // START held: runs every 4*SETTLE+1 cycles, none queued while busy
    gate = GNand;
    START = 1'b1;
    tick();
    t = 0;
    ndone = 0;
    while (ndone < 3 && t < 40) begin
      tick();
      t++;
      if (DONE) begin
        done_at[ndone] = t;
        ndone++;
        exp_cnt = exp_cnt + 8'd1;
        check($sformatf("held cnt %0d", ndone), {24'd0, RUN_CNT}, {24'd0, exp_cnt});
        if (ndone == 3) START = 1'b0;
      end
    end
    check("held ndone", ndone, 3);
    check("held done0", done_at[0], 8);
    check("held done1", done_at[1], 17);
    check("held done2", done_at[2], 26);
    tick();
    check("held idle", {31'd0, BUSY}, 32'd0);

    // Reset at edge 5 of a run aborts without DONE
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int e = 1; e < 5; e++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_reset("abort e5");
    tick();
    check("abort e6 done", {31'd0, DONE}, 32'd0);
    exp_cnt = 8'd0;
    do_run("after abort", 4'b0000, 8);

    // Reset beats START on the same edge
    RST = 1'b1;
    START = 1'b1;
    tick();
    RST = 1'b0;
    START = 1'b0;
    check_reset("rst prio");
    exp_cnt = 8'd0;

    // 256 passing runs: counter wraps to zero
    all_pass = 1'b1;
    for (int r = 1; r <= 256; r++) begin
      START = 1'b1;
      tick();
      START = 1'b0;
      t = 0;
      while (!DONE && t < 100) begin
        tick();
        t++;
      end
      all_pass = all_pass & PASS & DONE;
      if (r == 255) check("wrap 255", {24'd0, RUN_CNT}, 32'd255);
    end
    check("wrap 256", {24'd0, RUN_CNT}, 32'd0);
    check("wrap all pass", {31'd0, all_pass}, 32'd1);
    check("wrap final pass", {31'd0, PASS}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
